spi_wbuf: RTL and testbench

//  SPI-slave write path: deserializes MOSI into a 16-bit start address followed by 16-bit data words,

---
 rtl/spi_wbuf.sv | 103 ++++++++++
 tb/tb_spi_wbuf.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_wbuf.sv
// SPI-slave write path: collects a 16-bit start address, then turns each following 16-bit word
// into a regfile write (address auto-increments by 2) or a FIFO push when the address is FIFO_ADDR.
module spi_wbuf #(
  parameter logic [15:0] FIFO_ADDR = 16'haaaa
) (
  input  logic        sck,
  input  logic        rstn,
  input  logic        csn_rstn,
  input  logic        wr_start,
  input  logic        mosi,
  output logic        regfile_wr,
  output logic [15:0] wregfile_addr,
  output logic [15:0] wregfile_data,
  output logic        fifo_wr,
  output logic [15:0] fifo_wdata,
  input  logic        fifo_full,
  output logic        wr_ovf
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t      state;
  logic [3:0]  bit_cnt;
  logic [14:0] shift;
  logic [15:0] waddr;
  logic [15:0] word;
  logic        last_bit;
  logic        addr_done;
  logic        word_done;
  logic        is_fifo;

  assign word      = {shift, mosi};
  assign last_bit  = (bit_cnt == 4'd15) && !wr_start;
  assign addr_done = (state == ADDR) && last_bit;
  assign word_done = (state == DATA) && last_bit;
  assign is_fifo   = (waddr == FIFO_ADDR);

  // Frame state: cleared by either reset, so a csn rise discards any partial word.
  always_ff @(posedge sck or negedge rstn or negedge csn_rstn) begin
    if (!rstn || !csn_rstn) begin
      state      <= IDLE;
      bit_cnt    <= 4'd0;
      shift      <= 15'd0;
      regfile_wr <= 1'b0;
      fifo_wr    <= 1'b0;
    end else begin
      regfile_wr <= 1'b0;
      fifo_wr    <= 1'b0;
      case (state)
        IDLE: begin
          if (wr_start) begin
            state   <= ADDR;
            bit_cnt <= 4'd0;
          end
        end
        ADDR, DATA: begin
          if (wr_start) begin
            state   <= ADDR;
            bit_cnt <= 4'd0;
            shift   <= 15'd0;
          end else begin
            shift   <= word[14:0];
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd15) begin
              state <= DATA;
              if (state == DATA) begin
                regfile_wr <= !is_fifo;
                fifo_wr    <= is_fifo && !fifo_full;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Address and output data survive csn_rstn; frame state is IDLE then, so nothing updates.
  always_ff @(posedge sck or negedge rstn) begin
    if (!rstn) begin
      waddr         <= 16'd0;
      wregfile_addr <= 16'd0;
      wregfile_data <= 16'd0;
      fifo_wdata    <= 16'd0;
      wr_ovf        <= 1'b0;
    end else begin
      if (addr_done)
        waddr <= word;
      if (word_done) begin
        if (is_fifo) begin
          fifo_wdata <= word;
          if (fifo_full)
            wr_ovf <= 1'b1;
        end else begin
          wregfile_addr <= waddr;
          wregfile_data <= word;
          waddr         <= waddr + 16'd2;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_wbuf.sv
// Directed bench for spi_wbuf: table of two-word frames plus hand sequences for
// overflow stickiness, csn abort and mid-frame wr_start restart.
module tb_spi_wbuf;

  logic        sck = 1'b0;
  logic        rstn = 1'b0;
  logic        csn_rstn = 1'b0;
  logic        wr_start = 1'b0;
  logic        mosi = 1'b0;
  logic        fifo_full = 1'b0;
  logic        regfile_wr;
  logic [15:0] wregfile_addr;
  logic [15:0] wregfile_data;
  logic        fifo_wr;
  logic [15:0] fifo_wdata;
  logic        wr_ovf;

  int n_vec = 0;
  int n_bad = 0;
  int rf_cnt = 0;
  int ff_cnt = 0;
  int base;

  spi_wbuf dut (
    .sck(sck), .rstn(rstn), .csn_rstn(csn_rstn), .wr_start(wr_start), .mosi(mosi),
    .regfile_wr(regfile_wr), .wregfile_addr(wregfile_addr), .wregfile_data(wregfile_data),
    .fifo_wr(fifo_wr), .fifo_wdata(fifo_wdata), .fifo_full(fifo_full), .wr_ovf(wr_ovf)
  );

  always #5 sck = ~sck;

  always @(negedge sck) begin
    if (regfile_wr) rf_cnt++;
    if (fifo_wr) ff_cnt++;
  end

  typedef struct {
    logic [15:0] addr;
    logic [15:0] w0;
    logic [15:0] w1;
    logic        full1;
    logic        is_rf;
    logic        ff1;
    logic [15:0] a0;
    logic [15:0] a1;
    logic        ovf;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic b, input logic ws);
    @(negedge sck);
    mosi = b;
    wr_start = ws;
  endtask

  task automatic start_frame(input logic [15:0] a);
    drive(1'b1, 1'b1);
    for (int i = 15; i >= 0; i--) drive(a[i], 1'b0);
  endtask

  // Leaves time at posedge+1 of the completing edge.
  task automatic send_word(input logic [15:0] w, input logic full);
    for (int i = 15; i >= 0; i--) begin
      drive(w[i], 1'b0);
      if (i == 0) fifo_full = full;
    end
    @(posedge sck);
    #1;
  endtask

  task automatic do_reset();
    @(negedge sck);
    rstn = 1'b0;
    csn_rstn = 1'b0;
    fifo_full = 1'b0;
    #2;
    rstn = 1'b1;
    csn_rstn = 1'b1;
  endtask

  task automatic csn_pulse();
    @(negedge sck);
    csn_rstn = 1'b0;
    #2;
    csn_rstn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{16'h0010, 16'h1234, 16'hABCD, 1'b0, 1'b1, 1'b0, 16'h0010, 16'h0012, 1'b0};
    vecs[1] = '{16'hAAAA, 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0};
    vecs[2] = '{16'hAAAA, 16'h5555, 16'h6666, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1};
    vecs[3] = '{16'hFFFE, 16'h0F0F, 16'hF0F0, 1'b0, 1'b1, 1'b0, 16'hFFFE, 16'h0000, 1'b0};
    vecs[4] = '{16'h0011, 16'hBEEF, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0011, 16'h0013, 1'b0};
    vecs[5] = '{16'h8000, 16'h1357, 16'h2468, 1'b1, 1'b1, 1'b0, 16'h8000, 16'h8002, 1'b0};

    #12;
    check("rst_regfile_wr", regfile_wr, 1'b0);
    check("rst_fifo_wr", fifo_wr, 1'b0);
    check("rst_wr_ovf", wr_ovf, 1'b0);
    check("rst_addr", wregfile_addr, 16'h0000);
    check("rst_fifo_wdata", fifo_wdata, 16'h0000);
    rstn = 1'b1;
    csn_rstn = 1'b1;

    for (int k = 0; k < 6; k++) begin
      do_reset();
      start_frame(vecs[k].addr);
      base = rf_cnt;
      send_word(vecs[k].w0, 1'b0);
      check("w0_regfile_wr", regfile_wr, vecs[k].is_rf);
      check("w0_fifo_wr", fifo_wr, !vecs[k].is_rf);
      if (vecs[k].is_rf) begin
        check("w0_addr", wregfile_addr, vecs[k].a0);
        check("w0_data", wregfile_data, vecs[k].w0);
      end else begin
        check("w0_fifo_wdata", fifo_wdata, vecs[k].w0);
      end
      send_word(vecs[k].w1, vecs[k].full1);
      check("w1_regfile_wr", regfile_wr, vecs[k].is_rf);
      check("w1_fifo_wr", fifo_wr, vecs[k].ff1);
      if (vecs[k].is_rf) begin
        check("w1_addr", wregfile_addr, vecs[k].a1);
        check("w1_data", wregfile_data, vecs[k].w1);
      end else begin
        check("w1_fifo_wdata", fifo_wdata, vecs[k].w1);
      end
      check("wr_ovf", wr_ovf, vecs[k].ovf);
      drive(1'b0, 1'b0);
      fifo_full = 1'b0;
      @(posedge sck);
      #1;
      check("strobe_one_cycle", {regfile_wr, fifo_wr}, 2'b00);
      check("regfile_pulse_count", rf_cnt - base, vecs[k].is_rf ? 2 : 0);
    end

    // Overflow is sticky across csn_rstn and cleared only by rstn.
    do_reset();
    start_frame(16'hAAAA);
    send_word(16'h1111, 1'b0);
    check("ovf_first_push", fifo_wr, 1'b1);
    send_word(16'h2222, 1'b1);
    check("ovf_drop_push", fifo_wr, 1'b0);
    check("ovf_set", wr_ovf, 1'b1);
    fifo_full = 1'b0;
    csn_pulse();
    #1;
    check("ovf_hold_csn", wr_ovf, 1'b1);
    check("fifo_wdata_hold_csn", fifo_wdata, 16'h2222);
    do_reset();
    #1;
    check("ovf_clr_rstn", wr_ovf, 1'b0);
    check("fifo_wdata_clr_rstn", fifo_wdata, 16'h0000);

    // Frame aborted by csn after 9 data bits, then a fresh frame.
    do_reset();
    start_frame(16'h0080);
    for (int i = 0; i < 9; i++) drive(1'b1, 1'b0);
    csn_pulse();
    base = rf_cnt;
    start_frame(16'h0040);
    send_word(16'hC0DE, 1'b0);
    check("abort_no_strobe", rf_cnt - base, 0);
    check("abort_new_wr", regfile_wr, 1'b1);
    check("abort_new_addr", wregfile_addr, 16'h0040);
    check("abort_new_data", wregfile_data, 16'hC0DE);
    send_word(16'h0102, 1'b0);
    check("abort_next_addr", wregfile_addr, 16'h0042);

    // wr_start mid-DATA discards the partial word and recaptures the address.
    do_reset();
    start_frame(16'h0100);
    send_word(16'h1111, 1'b0);
    check("restart_first_addr", wregfile_addr, 16'h0100);
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0);
    base = rf_cnt;
    start_frame(16'h0200);
    send_word(16'h2222, 1'b0);
    check("restart_no_partial", rf_cnt - base, 0);
    check("restart_wr", regfile_wr, 1'b1);
    check("restart_addr", wregfile_addr, 16'h0200);
    check("restart_data", wregfile_data, 16'h2222);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
